reg_file_8x16: RTL

Eight-entry, 16-bit general-purpose register file for the RISC datapath. It is the read/write counterpart of the processor's single-bit storage flip-flops: one write port stores decoded results on the falling clock edge, and two independent combinational read ports feed the ALU operands. It sits between the writeback stage (write port) and the decode/operand-fetch stage (read ports).

---
 rtl/reg_file_8x16_pkg.sv | 13 +
 rtl/reg_file_8x16_if.sv | 19 +
 rtl/register_16_fe_ar.sv | 34 +++
 rtl/reg_file_8x16.sv | 41 ++++
 4 files changed

// File: rtl/reg_file_8x16_pkg.sv
// Shared sizing constants and types for the 8x16 register file.
package reg_file_8x16_pkg;

  localparam int REG_WIDTH  = 16;
  localparam int REG_ADDR_W = 3;
  localparam int REG_COUNT  = 8;

  localparam logic [REG_WIDTH-1:0] REG_ZERO = 16'h0000;

  typedef logic [REG_WIDTH-1:0]  reg_word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_8x16_if.sv
// Bus bundle between the datapath and the register file.
// Protocol: there is no valid/ready pair. A write is requested by holding
// WE=1 with WA/WD stable across a falling CLK edge; it takes effect at that
// edge. RA1/RA2 select the read data combinationally at any time.
interface reg_file_8x16_if;
  import reg_file_8x16_pkg::*;

  logic      WE;
  reg_addr_t WA;
  reg_word_t WD;
  reg_addr_t RA1;
  reg_addr_t RA2;
  reg_word_t RD1;
  reg_word_t RD2;

  modport master (output WE, WA, WD, RA1, RA2, input RD1, RD2);
  modport slave  (input WE, WA, WD, RA1, RA2, output RD1, RD2);

endinterface

// File: rtl/register_16_fe_ar.sv
// 16-bit falling-edge register with write enable and async active-high reset.
module register_16_fe_ar
  import reg_file_8x16_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  reg_word_t d,
  output reg_word_t q
);

  reg_word_t q_q;
  reg_word_t q_d;

  // Load new data only when enabled, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  // Storage updates on the falling edge; reset clears immediately.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      q_q <= REG_ZERO;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/reg_file_8x16.sv
// Eight-entry 16-bit register file: X0 reads as zero, X1..X7 are writable
// on the falling edge, two combinational read ports with no write bypass.
module reg_file_8x16
  import reg_file_8x16_pkg::*;
(
  input  logic            CLK,
  input  logic            R,
  reg_file_8x16_if.slave  bus
);

  // Decoder output 0 does not exist: X0 has no storage, so writes to it vanish.
  logic [REG_COUNT-1:1] wr_en;
  reg_word_t            regs [REG_COUNT];

  // Write address decode gated by the write enable.
  always_comb begin
    wr_en = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      wr_en[i] = bus.WE && (bus.WA == REG_ADDR_W'(i));
    end
  end

  assign regs[0] = REG_ZERO;

  for (genvar g = 1; g < REG_COUNT; g++) begin : g_reg
    register_16_fe_ar u_reg (
      .clk (CLK),
      .rst (R),
      .en  (wr_en[g]),
      .d   (bus.WD),
      .q   (regs[g])
    );
  end

  // Two independent read muxes straight from stored state.
  always_comb begin
    bus.RD1 = regs[bus.RA1];
    bus.RD2 = regs[bus.RA2];
  end

endmodule
